mul_sos_mw_seq: RTL and testbench
=================================

# mul_sos_mw_seq

Parametrised sequential multi-precision unsigned multiplier: computes r = a × b for N-word operands of W-bit words, using operand scanning (SOS). It reuses one W×W combinational word multiplier for N² cycles. It is the generic successor of the fixed 256-bit, 4×64 multiplier feeding the SM2 modular-multiplication datapath. Compared with that block it adds a valid/ready start handshake, an explicit state machine, an abort input, and a result that stays valid until the next operation is accepted.

## Interface
Reset is `rst_n`: asynchronous, active-low. Clock is `clk`.

Parameters:
- `W`, default 64: word width in bits.
- `N`, default 4: words per operand, N ≥ 2. Operand width is W·N; result width is 2·W·N.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `start_vld_i`  in  1  operands valid
- `start_rdy_o`  out  1  block can accept operands
- `a_i`  in  W·N  multiplicand, word 0 = LSW
- `b_i`  in  W·N  multiplier, word 0 = LSW
- `abort_i`  in  1  cancel the running operation
- `busy_o`  out  1  MAC sequence in progress
- `done_o`  out  1  one-cycle pulse: result valid
- `r_o`  out  2·W·N  product {R[2N-1]..R[0]}; valid from `done_o` until the next accept

## Operation
- **States.** IDLE, RUN, DONE. Reset enters IDLE with counters = 0, R[*] = 0, carry = 0, operand regs = 0, `done_o` = 0, `busy_o` = 0, `start_rdy_o` = 1.
- **Readiness.** `start_rdy_o` = (state ≠ RUN).
- **Accept.** An accept occurs on `start_vld_i` && `start_rdy_o`. On accept: latch `a_i`/`b_i` into A[0..N-1]/B[0..N-1], clear R[*] and carry, set i = j = 0, go to RUN.
- **RUN, one MAC per cycle.** p = B[i]·A[j] (2W bits).
  - j = 0: {carry, R[i]} ← p + R[i].
  - 0 < j < N-1: {carry, R[i+j]} ← p + carry + R[i+j].
  - j = N-1: {R[i+N], R[i+N-1]} ← p + carry + R[i+N-1].
  - The sum is computed at 2W+1 bits. Bit 2W is provably 0, so carry is W bits wide.
- **Counters.** j increments every RUN cycle and wraps at N-1. On wrap, i increments. When i = j = N-1, the MAC completes and the state goes to DONE.
- **DONE.** Lasts one cycle: `done_o` = 1, then return to IDLE. R holds.
- **Abort.** `abort_i` in RUN goes to IDLE next cycle. No `done_o` is produced and R contents are don't-care. `abort_i` is ignored in IDLE and DONE; in those states an accept in the same cycle takes effect normally.
- **Start during RUN.** `start_vld_i` is not accepted in RUN; the source must hold it.

## Timing
- Accept at edge 0. MACs occur on edges 1..N². The state is DONE (`done_o` high) in the cycle after edge N², i.e. latency N²+1 cycles. W=64, N=4 gives 17 cycles.
- `busy_o` is high for exactly N² cycles per operation.
- **Back-to-back.** An accept in the DONE cycle is legal. `r_o` stays valid through that cycle and R clears on the following edge. Throughput is one operation per N²+1 cycles.
- **Outputs.** `done_o`, `busy_o` and `start_rdy_o` are registered or state-decoded with no combinational path from inputs.
- **Reset mid-operation.** Reset asserted during RUN forces the reset values immediately. No `done_o` follows.
- **Critical path.** W×W multiplier plus (2W+1)-bit add, in a single cycle. No multiplier pipelining in this revision.

## Structure
- Shared package `sm2_mul_pkg` holds:
  - the state encoding (IDLE/RUN/DONE);
  - a `CNT_W` = $clog2(N) helper;
  - default W/N constants.
- Sub-module `mul_word_wrapper`: W×W → 2W combinational unsigned multiplier, parameter W. It is the technology-replaceable IP shim, instantiated once.
- Word-select muxes, the accumulator bank R[0..2N-1], counters and the FSM live in this module.

## Test plan
- W=64, N=4, a = b = 2²⁵⁶−1 → `r_o` = 2⁵¹²−2²⁵⁷+1; `done_o` exactly 17 cycles after accept; `busy_o` high for 16 cycles.
- W=8, N=2, a = 0xFFFF, b = 0xFFFF → `r_o` = 0xFFFE0001; `done_o` 5 cycles after accept.
- W=64, N=4, a = 1, b = 0x0123…CDEF (random 256-bit) → `r_o` = b, zero-extended. Then 1000 random pairs compared against a reference `*` model.
- Back-to-back: hold `start_vld_i` high through two operations → second accept coincides with the first `done_o`; both results correct; no lost or duplicated `done_o`.
- Abort: assert `abort_i` at MAC cycle 7 → IDLE next cycle, `start_rdy_o` = 1, no `done_o`. The next operation (3 × 5) yields 15.
- Reset: assert `rst_n` low at MAC cycle 9 → all outputs at reset values immediately, `r_o` = 0, no `done_o` after release.

Source files
------------

// File: rtl/sm2_mul_pkg.sv
// Shared definitions for the sequential operand-scanning multiplier:
// FSM encoding, counter-width helper and default geometry.
package sm2_mul_pkg;

  localparam int DEF_W = 64;
  localparam int DEF_N = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_word_wrapper.sv
// W x W -> 2W unsigned combinational multiplier; the single place to swap in
// a technology-specific multiplier macro.
module mul_word_wrapper #(
  parameter int W = 64
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-1:0] p_o
);

  assign p_o = {{W{1'b0}}, a_i} * {{W{1'b0}}, b_i};

endmodule

// File: rtl/mul_sos_mw_seq.sv
// Multi-precision unsigned multiplier r = a * b, one W x W multiply-accumulate
// per cycle in operand-scanning order (row i = B[i], column j = A[j]).
module mul_sos_mw_seq
  import sm2_mul_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_vld_i,
  output logic             start_rdy_o,
  input  logic [W*N-1:0]   a_i,
  input  logic [W*N-1:0]   b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2*W*N-1:0] r_o
);

  localparam int               CNT_W = cnt_w(N);
  localparam int               IDX_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] i_q, i_d;
  logic [CNT_W-1:0] j_q, j_d;
  logic [W-1:0]     carry_q, carry_d;
  logic [W-1:0]     a_q [N];
  logic [W-1:0]     a_d [N];
  logic [W-1:0]     b_q [N];
  logic [W-1:0]     b_d [N];
  logic [W-1:0]     r_q [2*N];
  logic [W-1:0]     r_d [2*N];

  logic [W-1:0]     a_word, b_word, r_word, carry_in;
  logic [2*W-1:0]   prod, sum;
  logic [IDX_W-1:0] idx, idx_hi;

  assign a_word   = a_q[j_q];
  assign b_word   = b_q[i_q];
  assign idx      = IDX_W'(i_q) + IDX_W'(j_q);
  assign idx_hi   = idx + IDX_W'(1);
  assign r_word   = r_q[idx];
  assign carry_in = (j_q == '0) ? '0 : carry_q;

  mul_word_wrapper #(.W(W)) u_mul (
    .a_i (a_word),
    .b_i (b_word),
    .p_o (prod)
  );

  // The carry-out above 2W bits cannot occur: (2^W-1)^2 + 2*(2^W-1) = 2^(2W) - 1.
  assign sum = prod + {{W{1'b0}}, carry_in} + {{W{1'b0}}, r_word};

  always_comb begin
    // NOTE: every target gets a default first so no path holds an old value (no latch).
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_vld_i) begin
          for (int k = 0; k < N; k++) begin
            a_d[k] = a_i[k*W +: W];
            b_d[k] = b_i[k*W +: W];
          end
          for (int k = 0; k < 2*N; k++) r_d[k] = '0;
          carry_d = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (abort_i) begin
          i_d     = '0;
          j_d     = '0;
          state_d = ST_IDLE;
        end else begin
          r_d[idx] = sum[W-1:0];
          if (j_q == LAST) begin
            // Last column of a row: the high half lands in the fresh word above.
            r_d[idx_hi] = sum[2*W-1:W];
            j_d         = '0;
            if (i_q == LAST) begin
              i_d     = '0;
              state_d = ST_DONE;
            end else begin
              i_d = i_q + CNT_W'(1);
            end
          end else begin
            carry_d = sum[2*W-1:W];
            j_d     = j_q + CNT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the accumulator and operand banks are reset as well, since r_o must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      carry_q <= '0;
      a_q     <= '{default: '0};
      b_q     <= '{default: '0};
      r_q     <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
    end
  end

  assign start_rdy_o = (state_q != ST_RUN);
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = (state_q == ST_DONE);

  for (genvar g = 0; g < 2*N; g++) begin : g_r_out
    assign r_o[g*W +: W] = r_q[g];
  end

endmodule

// File: tb/tb_mul_sos_mw_seq.sv
// Bench for mul_sos_mw_seq: table vectors and random pairs through a result
// scoreboard, plus latency, back-to-back, abort and reset sequences.
module tb_mul_sos_mw_seq;

  localparam int W   = 64;
  localparam int N   = 4;
  localparam int OPW = W * N;
  localparam int RW  = 2 * OPW;
  localparam int SW  = 8;
  localparam int SN  = 2;
  localparam int LAT = N * N + 1;

  typedef logic [OPW-1:0] op_t;
  typedef logic [RW-1:0]  res_t;
  typedef struct {
    op_t  a;
    op_t  b;
    res_t exp;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic     start_vld = 1'b0;
  logic     abort_in  = 1'b0;
  op_t      a_in      = '0;
  op_t      b_in      = '0;
  logic     start_rdy_o, busy_o, done_o;
  res_t     r_o;

  logic              s_vld = 1'b0;
  logic [SW*SN-1:0]  s_a   = '0;
  logic [SW*SN-1:0]  s_b   = '0;
  logic              s_rdy, s_busy, s_done;
  logic [2*SW*SN-1:0] s_r;

  int   tests = 0;
  int   fails = 0;
  int   done_seen = 0;
  int   done_expected = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  mul_sos_mw_seq #(.W(W), .N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_vld_i (start_vld),
    .start_rdy_o (start_rdy_o),
    .a_i         (a_in),
    .b_i         (b_in),
    .abort_i     (abort_in),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .r_o         (r_o)
  );

  mul_sos_mw_seq #(.W(SW), .N(SN)) dut_small (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_vld_i (s_vld),
    .start_rdy_o (s_rdy),
    .a_i         (s_a),
    .b_i         (s_b),
    .abort_i     (1'b0),
    .busy_o      (s_busy),
    .done_o      (s_done),
    .r_o         (s_r)
  );

  task automatic check(input string name, input res_t act, input res_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic res_t ref_mul(input op_t a, input op_t b);
    return res_t'(a) * res_t'(b);
  endfunction

  function automatic op_t rand_op();
    op_t v;
    for (int k = 0; k < OPW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Scoreboard: each done_o pops the oldest outstanding expected product.
  always @(negedge clk) begin
    if (rst_n && done_o === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done_o=1, expected no pending operation");
      end else begin
        check("result", r_o, exp_q.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic issue(input op_t a, input op_t b, input res_t exp);
    int waited = 0;
    a_in      = a;
    b_in      = b;
    start_vld = 1'b1;
    while (start_rdy_o !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (start_rdy_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got start_rdy_o=%b after %0d cycles, expected 1", start_rdy_o, waited);
    end else begin
      exp_q.push_back(exp);
      done_expected++;
    end
    @(negedge clk);
    start_vld = 1'b0;
  endtask

  // Latency counts from the accept cycle to the done cycle inclusive.
  task automatic wait_done(output int lat, output int busy_n);
    int n = 0;
    busy_n = 0;
    while (done_o !== 1'b1 && n < 100) begin
      if (busy_o === 1'b1) busy_n++;
      @(negedge clk);
      n++;
    end
    if (done_o !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done_o within %0d cycles, expected %0d", n, LAT);
    end
    lat = n + 1;
  endtask

  vec_t vecs[7];
  op_t  b_pat;
  op_t  ra, rb, ra2, rb2;
  res_t re;
  int   lat, busy_n, hits, n;

  initial begin
    b_pat = 256'h0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF_0123456789ABCDEF;
    vecs[0] = '{a: '1, b: '1, exp: {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1}};
    vecs[1] = '{a: op_t'(1), b: b_pat, exp: {256'd0, b_pat}};
    vecs[2] = '{a: '0, b: '1, exp: '0};
    vecs[3] = '{a: op_t'(1) << 255, b: op_t'(2), exp: res_t'(1) << 256};
    vecs[4] = '{a: op_t'(64'hFFFF_FFFF_FFFF_FFFF), b: op_t'(64'hFFFF_FFFF_FFFF_FFFF),
                exp: {384'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1}};
    vecs[5] = '{a: op_t'(1) << 192, b: op_t'(1) << 192, exp: res_t'(1) << 384};
    vecs[6] = '{a: '1, b: op_t'(2), exp: {255'd0, {256{1'b1}}, 1'b0}};

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_i("rst_start_rdy", int'(start_rdy_o), 1);
    check_i("rst_busy", int'(busy_o), 0);
    check_i("rst_done", int'(done_o), 0);
    check("rst_r", r_o, '0);
    check("rst_small_r", res_t'(s_r), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Small geometry W=8, N=2: latency N^2+1 = 5.
    s_a   = 16'hFFFF;
    s_b   = 16'hFFFF;
    s_vld = 1'b1;
    @(negedge clk);
    s_vld  = 1'b0;
    n      = 0;
    busy_n = 0;
    while (s_done !== 1'b1 && n < 50) begin
      if (s_busy === 1'b1) busy_n++;
      @(negedge clk);
      n++;
    end
    check_i("small_latency", n + 1, 5);
    check_i("small_busy", busy_n, 4);
    check("small_result", res_t'(s_r), res_t'(32'hFFFE_0001));
    @(negedge clk);

    foreach (vecs[v]) begin
      issue(vecs[v].a, vecs[v].b, vecs[v].exp);
      wait_done(lat, busy_n);
      check_i($sformatf("vec%0d_latency", v), lat, LAT);
      check_i($sformatf("vec%0d_busy", v), busy_n, N * N);
      @(negedge clk);
      check_i($sformatf("vec%0d_done_pulse", v), int'(done_o), 0);
      check($sformatf("vec%0d_r_hold", v), r_o, vecs[v].exp);
    end

    // Back-to-back: start_vld held, second accept lands in the first DONE cycle.
    ra = rand_op(); rb = rand_op(); ra2 = rand_op(); rb2 = rand_op();
    a_in = ra; b_in = rb; start_vld = 1'b1;
    exp_q.push_back(ref_mul(ra, rb));
    done_expected++;
    @(negedge clk);
    a_in = ra2; b_in = rb2;
    n = 0;
    while (start_rdy_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_i("b2b_done_at_accept", int'(done_o), 1);
    check_i("b2b_gap", n, N * N);
    exp_q.push_back(ref_mul(ra2, rb2));
    done_expected++;
    @(negedge clk);
    start_vld = 1'b0;
    check_i("b2b_second_busy", int'(busy_o), 1);
    wait_done(lat, busy_n);
    check_i("b2b_second_latency", lat, LAT);
    @(negedge clk);

    // Abort in the 7th MAC cycle.
    ra = rand_op(); rb = rand_op();
    issue(ra, rb, ref_mul(ra, rb));
    repeat (6) @(negedge clk);
    abort_in = 1'b1;
    @(negedge clk);
    abort_in = 1'b0;
    check_i("abort_busy", int'(busy_o), 0);
    check_i("abort_start_rdy", int'(start_rdy_o), 1);
    check_i("abort_done", int'(done_o), 0);
    void'(exp_q.pop_back());
    done_expected--;
    hits = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_o === 1'b1) hits++;
    end
    check_i("abort_no_done", hits, 0);
    issue(op_t'(3), op_t'(5), res_t'(15));
    wait_done(lat, busy_n);
    check("abort_next_3x5", r_o, res_t'(15));
    @(negedge clk);

    // abort_i is ignored while idle; an accept in that cycle proceeds.
    ra = rand_op(); rb = rand_op();
    abort_in = 1'b1;
    issue(ra, rb, ref_mul(ra, rb));
    abort_in = 1'b0;
    check_i("idle_abort_ignored", int'(busy_o), 1);
    wait_done(lat, busy_n);
    check_i("idle_abort_latency", lat, LAT);
    @(negedge clk);

    for (int t = 0; t < 1000; t++) begin
      ra = rand_op();
      rb = rand_op();
      if (t % 4 == 0) ra[OPW-1 -: 64] = '1;
      re = ref_mul(ra, rb);
      issue(ra, rb, re);
      wait_done(lat, busy_n);
      @(negedge clk);
    end

    // Reset in the 9th MAC cycle.
    ra = rand_op(); rb = rand_op();
    issue(ra, rb, ref_mul(ra, rb));
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_i("mid_rst_busy", int'(busy_o), 0);
    check_i("mid_rst_done", int'(done_o), 0);
    check_i("mid_rst_start_rdy", int'(start_rdy_o), 1);
    check("mid_rst_r", r_o, '0);
    void'(exp_q.pop_back());
    done_expected--;
    @(negedge clk);
    rst_n = 1'b1;
    hits = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o === 1'b1) hits++;
    end
    check_i("mid_rst_no_done", hits, 0);
    check("mid_rst_r_after", r_o, '0);

    check_i("scoreboard_empty", exp_q.size(), 0);
    check_i("done_count", done_seen, done_expected);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
